// File: rtl/spi_rom_pkg.sv
// Shared constants and state encoding for the SPI flash read engine.
package spi_rom_pkg;

    // Standard SPI NOR "READ" opcode (no dummy cycles).
    localparam logic [7:0]  READ_OPCODE = 8'h03;
    localparam int unsigned CMD_BITS    = 8;
    localparam int unsigned ADDR_BITS   = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        TAIL
    } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: half-period counter producing a mode-0 SCK with
// rise/fall strobes that coincide with the clk edge where SCK changes.
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic stall_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       tick;

    // A toggle happens on the edge where the counter has spent a full half-period.
    assign tick   = en_i && !stall_i && (cnt_q == 8'(CLK_DIV - 1));
    assign rise_o = tick && !sck_q;
    assign fall_o = tick && sck_q;
    assign sck_o  = sck_q;

    // Next-state for the half-period counter; stall freezes both counter and SCK.
    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (!stall_i) begin
            if (tick) begin
                cnt_d = '0;
                sck_d = !sck_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Counter and SCK registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_rom_reader.sv
// SPI NOR flash sequential reader: issues READ (0x03) + 24-bit address,
// then streams len bytes out through a valid/ready port with backpressure.
module spi_rom_reader
    import spi_rom_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t      state_q;
    logic        busy_q, done_q, cs_n_q;
    logic [31:0] tx_q;
    logic [7:0]  rx_q, out_data_q, tail_cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] byte_cnt_q;
    logic        last_q, byte_rdy_q, out_valid_q;
    logic        sck, sck_rise, sck_fall, sck_en, stall;

    assign sck_en = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);

    // Hold SCK low before the first bit of a byte while the previous byte is unconsumed.
    assign stall = (state_q == DATA) && (bit_cnt_q == '0) && !sck
                   && out_valid_q && !out_ready;

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (sck_en),
        .stall_i(stall),
        .sck_o  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // Transaction FSM: command/address shift-out, data shift-in, output handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            tail_cnt_q  <= '0;
            last_q      <= 1'b0;
            byte_rdy_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            byte_rdy_q <= 1'b0;

            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            // The completed byte is presented one clk after its 8th sample.
            if (byte_rdy_q) begin
                out_data_q  <= rx_q;
                out_valid_q <= 1'b1;
            end

            // MOSI is tx_q[31]; zeros shift in behind the address so MOSI is 0 in DATA.
            if (sck_fall) begin
                tx_q <= {tx_q[30:0], 1'b0};
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q    <= CMD;
                            busy_q     <= 1'b1;
                            cs_n_q     <= 1'b0;
                            tx_q       <= {READ_OPCODE, addr};
                            byte_cnt_q <= len;
                            bit_cnt_q  <= '0;
                            last_q     <= 1'b0;
                        end
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                            state_q   <= ADDR;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        rx_q <= {rx_q[6:0], spi_miso};
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q  <= '0;
                            byte_rdy_q <= 1'b1;
                            byte_cnt_q <= byte_cnt_q - 16'd1;
                            if (byte_cnt_q == 16'd1) begin
                                last_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    if (sck_fall && last_q) begin
                        state_q    <= TAIL;
                        tail_cnt_q <= '0;
                    end
                end
                TAIL: begin
                    if (tail_cnt_q == 8'(CLK_DIV - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        tail_cnt_q <= tail_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sck   = sck;
    assign spi_mosi  = tx_q[31];

endmodule
